// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register offsets, CTRL bit positions and byte-strobe merge for mtimer_responder
package mtimer_pkg;

    localparam logic [2:0] MTIME_LO_OFF    = 3'd0;
    localparam logic [2:0] MTIME_HI_OFF    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO_OFF = 3'd2;
    localparam logic [2:0] MTIMECMP_HI_OFF = 3'd3;
    localparam logic [2:0] CTRL_OFF        = 3'd4;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_PSC_LSB = 8;
    localparam int CTRL_PSC_MSB = 15;

    function automatic logic [31:0] apply_wsel(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] wsel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = wsel[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mtimer_responder.sv
// mtimer_responder: memory-mapped 64-bit mtime/mtimecmp timer driving the core timer interrupt.
// MTIMER_PRESCALER_EN adds CTRL.PSC and an 8-bit prescale counter.
module mtimer_responder
    import mtimer_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic        CTRL_RST_EN  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ena_i,
    input  logic [31:0] addr_i,
    input  logic        read_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  wsel_byte_i,
    input  logic [31:0] wdata_i,
    output logic        irq_timer_o
);

    logic [63:0] mtime, mtimecmp;
    logic        ctrl_en;
    logic [2:0]  off;
    logic        wr, rd, tick;
    logic [31:0] ctrl_word, rd_word;
    logic        unused_addr;

    assign off         = addr_i[4:2];
    assign wr          = ena_i && |wsel_byte_i;
    assign rd          = ena_i && read_i;
    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

`ifdef MTIMER_PRESCALER_EN
    logic [7:0] psc, psc_cnt;
    assign tick      = ctrl_en && psc_cnt == psc;
    assign ctrl_word = {16'h0, psc, 7'h0, ctrl_en};
`else
    assign tick      = ctrl_en;
    assign ctrl_word = {31'h0, ctrl_en};
`endif

    assign rd_word = off == MTIME_LO_OFF    ? mtime[31:0]     :
                     off == MTIME_HI_OFF    ? mtime[63:32]    :
                     off == MTIMECMP_LO_OFF ? mtimecmp[31:0]  :
                     off == MTIMECMP_HI_OFF ? mtimecmp[63:32] :
                     off == CTRL_OFF        ? ctrl_word       : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime       <= 64'h0;
            mtimecmp    <= MTIMECMP_RST;
            ctrl_en     <= CTRL_RST_EN;
            rdata_o     <= 32'h0;
            irq_timer_o <= 1'b0;
`ifdef MTIMER_PRESCALER_EN
            psc         <= 8'h0;
            psc_cnt     <= 8'h0;
`endif
        end else begin
            if (rd)
                rdata_o <= rd_word;
            irq_timer_o <= mtime >= mtimecmp;
            // a software write to either mtime word wins over this cycle's increment
            if (wr && off == MTIME_LO_OFF)
                mtime[31:0] <= apply_wsel(mtime[31:0], wdata_i, wsel_byte_i);
            else if (wr && off == MTIME_HI_OFF)
                mtime[63:32] <= apply_wsel(mtime[63:32], wdata_i, wsel_byte_i);
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr && off == MTIMECMP_LO_OFF)
                mtimecmp[31:0] <= apply_wsel(mtimecmp[31:0], wdata_i, wsel_byte_i);
            if (wr && off == MTIMECMP_HI_OFF)
                mtimecmp[63:32] <= apply_wsel(mtimecmp[63:32], wdata_i, wsel_byte_i);
            if (wr && off == CTRL_OFF && wsel_byte_i[0])
                ctrl_en <= wdata_i[CTRL_EN_BIT];
`ifdef MTIMER_PRESCALER_EN
            if (wr && off == CTRL_OFF && wsel_byte_i[1])
                psc <= wdata_i[CTRL_PSC_MSB:CTRL_PSC_LSB];
            psc_cnt <= (wr && off == CTRL_OFF) || tick ? 8'h0 : ctrl_en ? psc_cnt + 8'd1 : psc_cnt;
`endif
        end
    end

endmodule
